// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, H/V counters and registered sync decode.
// Optional `VGA_FRAME_CNT_EN adds an 8-bit frame counter output (frame_cnt).
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixel_tick,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP       = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP       = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [9:0]       h_d;
    logic [9:0]       v_d;
    logic             h_wrap;
    logic             frame_wrap;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        h_wrap     = (HCount == H_LAST);
        frame_wrap = pixel_tick && h_wrap && (VCount == V_LAST);
        h_d        = HCount;
        v_d        = VCount;
        if (pixel_tick) begin
            h_d = h_wrap ? '0 : HCount + 10'd1;
            if (h_wrap) begin
                v_d = (VCount == V_LAST) ? '0 : VCount + 10'd1;
            end
        end
    end

    // Syncs decode the next count values so they update on the same edge as the counts.
    // NOTE: sequential state uses non-blocking assignments only, so all registers sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            pixel_tick  <= 1'b0;
            HCount      <= '0;
            VCount      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_q       <= div_d;
            pixel_tick  <= (div_d == DIV_LAST);
            HCount      <= h_d;
            VCount      <= v_d;
            hsync       <= !((h_d >= H_SYNC_FIRST) && (h_d <= H_SYNC_LAST));
            vsync       <= !((v_d >= V_SYNC_FIRST) && (v_d <= V_SYNC_LAST));
            video_on    <= (h_d < H_DISP) && (v_d < V_DISP);
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboarded bench: a default-timing instance (CLK_DIV=2) and a tiny-raster CLK_DIV=1 instance.
// Expected samples are queued with a cycle stamp; a negedge monitor pops and compares them.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rst_s_n;
    logic       tk_a, hs_a, vs_a, von_a, fs_a;
    logic       tk_s, hs_s, vs_s, von_s, fs_s;
    logic [9:0] h_a, v_a, h_s, v_s;
    logic [7:0] fc_a, fc_s;

    vga_sync_gen dut_a (
        .clk         (clk),
        .rst_n       (rst_a_n),
        .pixel_tick  (tk_a),
        .HCount      (h_a),
        .VCount      (v_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .video_on    (von_a),
        .frame_start (fs_a)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_a)
`endif
    );

    // Small raster: H_TOTAL=15 (hsync 10..12), V_TOTAL=10 (vsync 7..8), 150 clks per frame.
    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (
        .clk         (clk),
        .rst_n       (rst_s_n),
        .pixel_tick  (tk_s),
        .HCount      (h_s),
        .VCount      (v_s),
        .hsync       (hs_s),
        .vsync       (vs_s),
        .video_on    (von_s),
        .frame_start (fs_s)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_s)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign fc_a = '0;
    assign fc_s = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       tk;
        logic       fs;
        logic [7:0] fc;
        string      name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_s[$];

    function automatic exp_t mk(input string name, input int cyc, input int h, input int v,
                                input bit hs, input bit vs, input bit von, input bit tk,
                                input bit fs, input int fc);
        exp_t e;
        e.name = name;
        e.cyc  = cyc;
        e.h    = 10'(h);
        e.v    = 10'(v);
        e.hs   = hs;
        e.vs   = vs;
        e.von  = von;
        e.tk   = tk;
        e.fs   = fs;
        e.fc   = 8'(fc);
        return e;
    endfunction

    task automatic cmp(input exp_t e, input logic tk, input logic [9:0] h, input logic [9:0] v,
                       input logic hs, input logic vs, input logic von, input logic fs,
                       input logic [7:0] fc);
        check({e.name, ".HCount"},      32'(h),   32'(e.h));
        check({e.name, ".VCount"},      32'(v),   32'(e.v));
        check({e.name, ".hsync"},       32'(hs),  32'(e.hs));
        check({e.name, ".vsync"},       32'(vs),  32'(e.vs));
        check({e.name, ".video_on"},    32'(von), 32'(e.von));
        check({e.name, ".pixel_tick"},  32'(tk),  32'(e.tk));
        check({e.name, ".frame_start"}, 32'(fs),  32'(e.fs));
`ifdef VGA_FRAME_CNT_EN
        check({e.name, ".frame_cnt"},   32'(fc),  32'(e.fc));
`endif
    endtask

    // Monitor: cycle stamps count negedges since reset release (stamp k = state after posedge k).
    int   cyc_a = 0, cyc_s = 0;
    int   hs_low_a = 0, vs_low_s = 0, fs_cnt_s = 0;
    exp_t ea, es;

    always @(negedge clk) begin
        if (!rst_a_n) begin
            cyc_a    = 0;
            hs_low_a = 0;
        end else begin
            cyc_a++;
            if (!hs_a) hs_low_a++;
        end
        if (!rst_s_n) begin
            cyc_s    = 0;
            vs_low_s = 0;
            fs_cnt_s = 0;
        end else begin
            cyc_s++;
            if (!vs_s) vs_low_s++;
            if (fs_s) fs_cnt_s++;
        end
        while (q_a.size() > 0 && q_a[0].cyc <= cyc_a) begin
            ea = q_a.pop_front();
            if (ea.cyc < cyc_a) check({ea.name, ".missed"}, 32'(cyc_a), 32'(ea.cyc));
            else cmp(ea, tk_a, h_a, v_a, hs_a, vs_a, von_a, fs_a, fc_a);
        end
        while (q_s.size() > 0 && q_s[0].cyc <= cyc_s) begin
            es = q_s.pop_front();
            if (es.cyc < cyc_s) check({es.name, ".missed"}, 32'(cyc_s), 32'(es.cyc));
            else cmp(es, tk_s, h_s, v_s, hs_s, vs_s, von_s, fs_s, fc_s);
        end
    end

    initial begin
        rst_a_n = 1'b0;
        rst_s_n = 1'b0;
        //                name            cyc   H    V  hs vs von tk fs fc
        q_a.push_back(mk("a_rst",          0,    0,   0, 1, 1, 1, 0, 0, 0));
        q_s.push_back(mk("s_rst",          0,    0,   0, 1, 1, 1, 0, 0, 0));
        q_a.push_back(mk("a_k1",           1,    0,   0, 1, 1, 1, 1, 0, 0));
        q_a.push_back(mk("a_k2",           2,    1,   0, 1, 1, 1, 0, 0, 0));
        q_a.push_back(mk("a_k3",           3,    1,   0, 1, 1, 1, 1, 0, 0));
        q_a.push_back(mk("a_von_last",     1279, 639, 0, 1, 1, 1, 1, 0, 0));
        q_a.push_back(mk("a_von_fall",     1280, 640, 0, 1, 1, 0, 0, 0, 0));
        q_a.push_back(mk("a_pre_hsync",    1311, 655, 0, 1, 1, 0, 1, 0, 0));
        q_a.push_back(mk("a_hsync_fall",   1312, 656, 0, 0, 1, 0, 0, 0, 0));
        q_a.push_back(mk("a_hsync_last",   1503, 751, 0, 0, 1, 0, 1, 0, 0));
        q_a.push_back(mk("a_hsync_rise",   1504, 752, 0, 1, 1, 0, 0, 0, 0));
        q_a.push_back(mk("a_line_end",     1599, 799, 0, 1, 1, 0, 1, 0, 0));
        q_a.push_back(mk("a_line_wrap",    1600, 0,   1, 1, 1, 1, 0, 0, 0));

        repeat (5) @(negedge clk);
        #1 rst_a_n = 1'b1;
        repeat (1610) @(negedge clk);
        #2;
        check("a_hsync_low_clks", 32'(hs_low_a), 32'd192);

        q_s.push_back(mk("s_k1",           1,    0,   0, 1, 1, 1, 1, 0, 0));
        q_s.push_back(mk("s_k2",           2,    1,   0, 1, 1, 1, 1, 0, 0));
        q_s.push_back(mk("s_von_last",     8,    7,   0, 1, 1, 1, 1, 0, 0));
        q_s.push_back(mk("s_von_fall",     9,    8,   0, 1, 1, 0, 1, 0, 0));
        q_s.push_back(mk("s_hsync_fall",   11,   10,  0, 0, 1, 0, 1, 0, 0));
        q_s.push_back(mk("s_hsync_last",   13,   12,  0, 0, 1, 0, 1, 0, 0));
        q_s.push_back(mk("s_hsync_rise",   14,   13,  0, 1, 1, 0, 1, 0, 0));
        q_s.push_back(mk("s_line_end",     15,   14,  0, 1, 1, 0, 1, 0, 0));
        q_s.push_back(mk("s_line_wrap",    16,   0,   1, 1, 1, 1, 1, 0, 0));
        q_s.push_back(mk("s_vdisp_end",    91,   0,   6, 1, 1, 0, 1, 0, 0));
        q_s.push_back(mk("s_pre_vsync",    105,  14,  6, 1, 1, 0, 1, 0, 0));
        q_s.push_back(mk("s_vsync_fall",   106,  0,   7, 1, 0, 0, 1, 0, 0));
        q_s.push_back(mk("s_vsync_last",   135,  14,  8, 1, 0, 0, 1, 0, 0));
        q_s.push_back(mk("s_vsync_rise",   136,  0,   9, 1, 1, 0, 1, 0, 0));
        q_s.push_back(mk("s_frame_end",    150,  14,  9, 1, 1, 0, 1, 0, 0));
        q_s.push_back(mk("s_frame_wrap",   151,  0,   0, 1, 1, 1, 1, 1, 1));
        q_s.push_back(mk("s_after_wrap",   152,  1,   0, 1, 1, 1, 1, 0, 1));
        q_s.push_back(mk("s_mid",          216,  5,   4, 1, 1, 1, 1, 0, 1));
        rst_s_n = 1'b1;
        repeat (216) @(negedge clk);
        #1;
        check("s_vsync_low_clks", 32'(vs_low_s), 32'd30);
        check("s_frame_pulses",   32'(fs_cnt_s), 32'd1);

        // Mid-frame reset at (5,4): the clear must be visible before the next clock edge.
        q_s.push_back(mk("s_midrst",       0,    0,   0, 1, 1, 1, 0, 0, 0));
        rst_s_n = 1'b0;
        #1;
        check("s_async_HCount",      32'(h_s),  32'd0);
        check("s_async_VCount",      32'(v_s),  32'd0);
        check("s_async_frame_start", 32'(fs_s), 32'd0);
        check("s_async_pixel_tick",  32'(tk_s), 32'd0);

        q_s.push_back(mk("s2_k1",          1,    0,   0, 1, 1, 1, 1, 0, 0));
        q_s.push_back(mk("s2_k2",          2,    1,   0, 1, 1, 1, 1, 0, 0));
        for (int n = 1; n <= 257; n++) begin
            q_s.push_back(mk($sformatf("s2_wrap%0d", n), 150 * n + 1, 0, 0, 1, 1, 1, 1, 1, n % 256));
        end
        repeat (3) @(negedge clk);
        #2 rst_s_n = 1'b1;
        repeat (38560) @(negedge clk);
        #2;
        check("s_frame_pulses_257", 32'(fs_cnt_s), 32'd257);
        check("a_sb_drain", 32'(q_a.size()), 32'd0);
        check("s_sb_drain", 32'(q_s.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
